rr_load_scheduler: RTL and testbench
====================================

// Module: rr_load_scheduler
// PURPOSE
//  Round-robin scheduler for the shared MUX + register datapath (4:1 MUX feeding an
//  enabled register). Arbitrates up to NREQ requesters and drives the MUX select and
//  register load-enable so each winner's operand is captured in the register. Tracks
//  register occupancy with a valid/ready handshake toward the downstream consumer.
//  Sits between the requesting units and the MUX/register pair in the CPU datapath.
// PARAMETERS
//  NREQ  4  number of requesters; equals the MUX input count; legal values 2..4
//  SELW  2  MUX select width; NREQ <= 2**SELW
// PORTS
//  clk        in   1     clock; all state changes on rising edge
//  rst        in   1     synchronous, active-high reset
//  req        in   NREQ  per-requester request; held high until matching gnt bit
//  sel        out  SELW  MUX select; index of the current winner
//  ld         out  1     register load-enable; register captures MUX output this edge
//  gnt        out  NREQ  one-hot grant; equals (1<<sel) when ld=1, else 0
//  out_valid  out  1     register holds an unconsumed value
//  out_ready  in   1     downstream consumes register value when out_valid & out_ready
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - State: FSM {IDLE, FULL}; last[SELW-1:0] = index of most recent winner.
//  - Reset (rst=1 at rising edge): state=IDLE, last=NREQ-1, out_valid=0. While rst=1,
//    ld=0, gnt=0, sel=0, regardless of req. Reset mid-FULL discards held value.
//  - Winner: first set bit of req scanning last+1, last+2, ... modulo NREQ (wrap).
//    Requester last has lowest priority; bits of req >= NREQ ignored.
//  - can_load = (state==IDLE) | (state==FULL & out_ready).
//  - ld = can_load & |req[NREQ-1:0] & ~rst  (combinational, same cycle as req).
//  - sel = winner index when ld=1; sel = last when ld=0 (MUX stays stable).
//  - gnt = ld ? (1<<sel) : 0. Requester deasserts req the cycle after its gnt bit.
//  - Latency: req seen in IDLE -> ld/gnt same cycle -> value in register and
//    out_valid=1 the next cycle. Zero-bubble throughput: one load per cycle while
//    out_ready=1 and requests are pending.
//  - Transitions at rising edge (rst=0):
//      IDLE: ld -> FULL, last<=sel; else stay IDLE.
//      FULL: out_ready & ld -> FULL, last<=sel (consume + reload same edge);
//            out_ready & ~ld -> IDLE; ~out_ready -> FULL, no load, register held.
//  - out_valid = (state==FULL), registered; reset value 0.
//  - Backpressure: while FULL & ~out_ready, ld=0 and gnt=0; pending reqs wait,
//    round-robin pointer unchanged.
//  - req dropped before grant: no grant issued, pointer unchanged.
//  - out_ready while IDLE: ignored.
//  - Fairness: with all NREQ requesting continuously and out_ready=1, each requester
//    is granted exactly once in any NREQ consecutive loads.
// TESTING
//  T1 reset: rst=1 two cycles with req=4'b1111 -> ld=0, gnt=0, sel=0, out_valid=0;
//     first cycle after rst=0 -> sel=0, gnt=4'b0001, ld=1.
//  T2 single: req=4'b0100 in IDLE, out_ready=1 -> same cycle sel=2, ld=1,
//     gnt=4'b0100; next cycle out_valid=1; req drops, next cycle -> IDLE, out_valid=0.
//  T3 rotation: req=4'b1111 held, out_ready=1 (requesters re-raise) -> sel sequence
//     0,1,2,3,0,1 on consecutive cycles, ld=1 every cycle; MUX ins 1,3,5,7 ->
//     register sequence 1,3,5,7,1,3.
//  T4 backpressure: FULL with last=1, out_ready=0 for 3 cycles, req=4'b1001 ->
//     ld=0, gnt=0, out_valid=1 all 3 cycles; out_ready=1 -> sel=3, gnt=4'b1000.
//  T5 wrap/skip: last=3, req=4'b0010 -> sel=1; then last=1, req=4'b0001 -> sel=0.
//  T6 reset mid-FULL: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0,
//     last=3; with req=4'b1000 next cycle -> sel=0? no: winner=3, gnt=4'b1000.

Source files
------------

// File: rtl/rr_load_scheduler.sv
// Round-robin scheduler for a shared MUX + load-enabled register.
// It picks a requester, drives the MUX select and the load, and tracks whether the register holds a value.
module rr_load_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [SELW-1:0] sel,
    output logic            ld,
    output logic [NREQ-1:0] gnt,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          r_state;
    logic [SELW-1:0] r_last;

    state_t          w_state_nxt;
    logic [SELW-1:0] w_last_nxt;
    logic [SELW-1:0] w_win;
    logic [SELW-1:0] w_idx;
    logic            w_found;
    logic            w_any;
    logic            w_can_load;
    logic            w_ld;

    // Scan last+1, last+2, ... modulo NREQ; the previous winner is checked last.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = SELW'((32'(r_last) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_any      = |req;
    assign w_can_load = (r_state == IDLE) || ((r_state == FULL) && out_ready);
    assign w_ld       = w_can_load && w_any && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        ld          = w_ld;
        sel         = '0;
        gnt         = '0;
        if (!rst) begin
            // When nothing is loaded the select holds the last winner so the MUX stays stable.
            sel = w_ld ? w_win : r_last;
        end
        if (w_ld) begin
            gnt = NREQ'(1) << sel;
        end
        case (r_state)
            IDLE: begin
                if (w_ld) begin
                    w_state_nxt = FULL;
                    w_last_nxt  = w_win;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (w_ld) begin
                        w_last_nxt = w_win;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= SELW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_rr_load_scheduler.sv
// Self-checking bench for rr_load_scheduler: cycle-by-cycle vector table plus
// rotation, fairness and drain sequences with a small MUX/register model.
module tb_rr_load_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SELW  = 2;
    localparam int unsigned NVEC  = 23;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [SELW-1:0] sel;
    logic            ld;
    logic [NREQ-1:0] gnt;
    logic            out_valid;
    logic            out_ready;

    int n_cmp;
    int n_err;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] req;
        logic            rdy;
        logic [SELW-1:0] sel;
        logic            ld;
        logic [NREQ-1:0] gnt;
        logic            vld;
    } vec_t;

    vec_t vecs [NVEC];

    logic [7:0] mux_in [NREQ];
    logic [7:0] tb_reg;

    rr_load_scheduler #(.NREQ(NREQ), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .ld        (ld),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register fed by the shared MUX; captures the selected input whenever ld is high.
    always @(posedge clk) begin
        if (ld) tb_reg <= mux_in[sel];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int          cnt [NREQ];
        int          exp_sel [6];
        logic [7:0]  exp_reg [6];
        int          waited;

        n_cmp = 0;
        n_err = 0;
        mux_in[0] = 8'd1; mux_in[1] = 8'd3; mux_in[2] = 8'd5; mux_in[3] = 8'd7;
        tb_reg = '0;
        exp_sel = '{0, 1, 2, 3, 0, 1};
        exp_reg = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd1, 8'd3};

        //           rst   req      rdy   sel   ld    gnt      vld
        vecs[0]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1};
        vecs[4]  = '{1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b1};
        vecs[6]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
        vecs[7]  = '{1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0};
        vecs[8]  = '{1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1};
        vecs[9]  = '{1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1};
        vecs[10] = '{1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1};
        vecs[11] = '{1'b0, 4'b1001, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b1};
        vecs[12] = '{1'b0, 4'b1001, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b1};
        vecs[13] = '{1'b0, 4'b1001, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b1};
        vecs[14] = '{1'b0, 4'b1001, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1};
        vecs[15] = '{1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1};
        vecs[16] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
        vecs[17] = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1};
        vecs[18] = '{1'b0, 4'b1110, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[19] = '{1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b1};
        vecs[20] = '{1'b1, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
        vecs[21] = '{1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0};
        vecs[22] = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1};

        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        @(posedge clk);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d.sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d.ld", i), 32'(ld), 32'(vecs[i].ld));
            check($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].vld));
        end

        // Rotation with all requesters active and no backpressure.
        @(negedge clk);
        rst = 1'b1; req = '0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req = 4'b1111;
            #1;
            check($sformatf("rot%0d.sel", k), 32'(sel), 32'(exp_sel[k]));
            check($sformatf("rot%0d.ld", k), 32'(ld), 32'd1);
            if (k > 0) check($sformatf("rot%0d.reg", k - 1), 32'(tb_reg), 32'(exp_reg[k - 1]));
            @(negedge clk);
        end
        #1;
        check("rot5.reg", 32'(tb_reg), 32'(exp_reg[5]));

        // Fairness: eight back-to-back loads give every requester exactly two grants.
        for (int j = 0; j < int'(NREQ); j++) cnt[j] = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req = 4'b1111;
            #1;
            for (int j = 0; j < int'(NREQ); j++) if (gnt[j]) cnt[j]++;
        end
        for (int j = 0; j < int'(NREQ); j++) check($sformatf("fair.cnt%0d", j), 32'(cnt[j]), 32'd2);

        // Drain: with requests gone, out_valid must drop within a bounded number of cycles.
        @(negedge clk);
        req = '0;
        waited = 0;
        while (out_valid && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        check("drain.out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
